dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 30 +++
 rtl/dmem_arbiter_rr_arb2.sv | 49 ++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids, debug view.
// The memory-clear feature is enabled in the top by defining DMEM_ARB_CLEAR_EN.
package dmem_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Observation point for checkers: FSM state and the port that won last.
  typedef struct packed {
    state_e state;
    port_e  last_gnt;
  } dbg_t;

  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int DEFAULT_ADDR_SIZE = 5;

  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  localparam int DEFAULT_DEPTH = depth_of(DEFAULT_ADDR_SIZE);

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-winner register.
// Grants are combinational; a tie goes to the port that did not win last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  logic  i_req_c,
  input  logic  i_req_d,
  output logic  o_gnt_c,
  output logic  o_gnt_d,
  output port_e o_last_gnt
);

  port_e r_last_gnt;
  logic  w_gnt_c;
  logic  w_gnt_d;

  // Nothing is granted while in reset or while the owner disables arbitration.
  always_comb begin
    w_gnt_c = 1'b0;
    w_gnt_d = 1'b0;
    if (i_en && !rst) begin
      if (i_req_c && i_req_d) begin
        if (r_last_gnt == PORT_D) w_gnt_c = 1'b1;
        else                      w_gnt_d = 1'b1;
      end else begin
        w_gnt_c = i_req_c;
        w_gnt_d = i_req_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= PORT_D;
    end else if (w_gnt_c) begin
      r_last_gnt <= PORT_C;
    end else if (w_gnt_d) begin
      r_last_gnt <= PORT_D;
    end
  end

  assign o_gnt_c    = w_gnt_c;
  assign o_gnt_d    = w_gnt_d;
  assign o_last_gnt = r_last_gnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (c_*) and debug/DMA (d_*) ports.
// Define DMEM_ARB_CLEAR_EN to zero the whole memory after every reset.
//
// Handshake: a requester holds req (with we/addr/wdata stable) until it sees gnt
// in the same cycle; the access happens at that clock edge. A granted read
// returns data with rvalid high for exactly the following cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [ADDR_SIZE-1:0] c_addr,
  input  logic [DATA_SIZE-1:0] c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [DATA_SIZE-1:0] c_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [DATA_SIZE-1:0] d_rdata,
  output logic                 mem_w,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output dbg_t                 o_dbg
);

  state_e r_state;
  state_e w_state_nxt;
  port_e  w_last_gnt;
  logic   w_run;

`ifdef DMEM_ARB_CLEAR_EN
  localparam int DEPTH = depth_of(ADDR_SIZE);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

  logic [ADDR_SIZE-1:0] r_clr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end
`endif

  assign w_run = (r_state == ST_RUN);

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_run),
    .i_req_c    (c_req),
    .i_req_d    (d_req),
    .o_gnt_c    (c_gnt),
    .o_gnt_d    (d_gnt),
    .o_last_gnt (w_last_gnt)
  );

  // Next state and the memory-side mux; the clear walk owns the memory outright.
  always_comb begin
    w_state_nxt = r_state;
    mem_w       = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;
    case (r_state)
      ST_CLEAR: begin
`ifdef DMEM_ARB_CLEAR_EN
        busy = 1'b1;
        if (!rst) begin
          mem_w    = 1'b1;
          mem_addr = r_clr_cnt;
          if (r_clr_cnt == LAST_ADDR) w_state_nxt = ST_RUN;
        end
`endif
      end
      ST_RUN: begin
`ifdef DMEM_ARB_CLEAR_EN
        busy = rst;
`endif
        if (c_gnt) begin
          mem_w     = c_we;
          mem_addr  = c_addr;
          mem_wdata = c_wdata;
        end else if (d_gnt) begin
          mem_w     = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end
      end
    endcase
  end

  // Read return: capture at the grant edge, data stays until that port reads again.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      d_rvalid <= d_gnt && !d_we;
      if (c_gnt && !c_we) c_rdata <= mem_rdata;
      if (d_gnt && !d_we) d_rdata <= mem_rdata;
    end
  end

  assign o_dbg.state    = r_state;
  assign o_dbg.last_gnt = w_last_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Build with DMEM_ARB_CLEAR_EN defined to exercise the clear-after-reset behaviour.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_w, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  dbg_t          dbg;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .o_dbg(dbg)
  );

  // Memory instance behind the arbiter, with a bench-side preload port.
  logic [DW-1:0] mem_array [DEPTH];
  logic          tb_w = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [DW-1:0] tb_wdata = '0;
  always @(posedge clk) begin
    if (mem_w)     mem_array[mem_addr] <= mem_wdata;
    else if (tb_w) mem_array[tb_waddr] <= tb_wdata;
  end
  assign mem_rdata = mem_array[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_c_q[$];
  logic [DW-1:0] exp_d_q[$];
  bit            ref_last_d;

  // ---------------- driver tasks ----------------
  task automatic drive_c(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic idle_all();
    drive_c(1'b0, 1'b0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    tb_w = 1'b1; tb_waddr = a; tb_wdata = v;
    next_cycle();
    tb_w = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
`ifdef DMEM_ARB_CLEAR_EN
    begin
      int k = 0;
      while (busy && k < 100) begin
        next_cycle();
        k++;
      end
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_clear_timeout busy=%b after %0d cycles, need 0", busy, k);
      end
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_busy;
`ifdef DMEM_ARB_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    rst = 1'b1;
    drive_c(1'b1, 1'b1, 5'd3, 8'h11);
    drive_d(1'b1, 1'b0, 5'd4, 8'h22);
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({c_gnt, d_gnt, mem_w, c_rvalid, d_rvalid, busy} !== {5'b0, exp_busy}) begin
      n_err++;
      $display("FAIL reset_ctrl got gnt=%b%b w=%b rv=%b%b busy=%b need 0000 0 busy=%b",
               c_gnt, d_gnt, mem_w, c_rvalid, d_rvalid, busy, exp_busy);
    end
    n_vec++;
    if ({c_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data got c_rdata=%h d_rdata=%h addr=%h wd=%h need all 0",
               c_rdata, d_rdata, mem_addr, mem_wdata);
    end
    next_cycle();
    do_reset();
  endtask

  task automatic test_write_read_core();
    drive_c(1'b1, 1'b1, 5'd5, 8'hA5);
    @(negedge clk);
    n_vec++;
    if ({c_gnt, d_gnt, mem_w, mem_addr, mem_wdata} !== {3'b101, 5'd5, 8'hA5}) begin
      n_err++;
      $display("FAIL wr_core_grant got gnt=%b%b w=%b addr=%h wd=%h need 10 1 05 a5",
               c_gnt, d_gnt, mem_w, mem_addr, mem_wdata);
    end
    next_cycle();
    drive_c(1'b1, 1'b0, 5'd5, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({c_gnt, mem_w, mem_addr, c_rvalid} !== {2'b10, 5'd5, 1'b0}) begin
      n_err++;
      $display("FAIL rd_core_grant got gnt=%b w=%b addr=%h rvalid=%b need 1 0 05 0",
               c_gnt, mem_w, mem_addr, c_rvalid);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, 8'hA5}) begin
      n_err++;
      $display("FAIL rd_core_data got rv=%b%b c_rdata=%h need 10 a5", c_rvalid, d_rvalid, c_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, mem_w, c_gnt} !== 3'b000) begin
      n_err++;
      $display("FAIL rd_core_pulse got rvalid=%b w=%b gnt=%b need 000", c_rvalid, mem_w, c_gnt);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    preload(5'd1, 8'h11);
    preload(5'd2, 8'h22);
    drive_c(1'b1, 1'b0, 5'd1, 8'h00);
    drive_d(1'b1, 1'b0, 5'd2, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({c_gnt, d_gnt, mem_addr} !== {2'b10, 5'd1}) begin
      n_err++;
      $display("FAIL sim_cycle0 got gnt=%b%b addr=%h need 10 01", c_gnt, d_gnt, mem_addr);
    end
    next_cycle();
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_vec++;
    if ({c_gnt, d_gnt, mem_addr, c_rvalid, d_rvalid, c_rdata} !== {2'b01, 5'd2, 2'b10, 8'h11}) begin
      n_err++;
      $display("FAIL sim_cycle1 got gnt=%b%b addr=%h rv=%b%b c_rdata=%h need 01 02 10 11",
               c_gnt, d_gnt, mem_addr, c_rvalid, d_rvalid, c_rdata);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, d_rvalid, d_rdata, c_rdata} !== {2'b01, 8'h22, 8'h11}) begin
      n_err++;
      $display("FAIL sim_cycle2 got rv=%b%b d_rdata=%h c_rdata=%h need 01 22 11",
               c_rvalid, d_rvalid, d_rdata, c_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    do_reset();
    preload(5'd10, 8'h5A);
    preload(5'd11, 8'hC3);
    drive_c(1'b1, 1'b0, 5'd10, 8'h00);
    drive_d(1'b1, 1'b0, 5'd11, 8'h00);
    for (int i = 0; i < 6; i++) begin
      logic exp_c;
      exp_c = (i % 2 == 0);
      @(negedge clk);
      n_vec++;
      if ({c_gnt, d_gnt} !== {exp_c, !exp_c}) begin
        n_err++;
        $display("FAIL contention_gnt%0d got %b%b need %b%b", i, c_gnt, d_gnt, exp_c, !exp_c);
      end
      n_vec++;
      if ({c_rvalid, d_rvalid} !== {(i > 0) && !exp_c, (i > 0) && exp_c}) begin
        n_err++;
        $display("FAIL contention_rv%0d got %b%b", i, c_rvalid, d_rvalid);
      end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, d_rvalid, c_rdata, d_rdata} !== {2'b01, 8'h5A, 8'hC3}) begin
      n_err++;
      $display("FAIL contention_data got rv=%b%b c=%h d=%h need 01 5a c3",
               c_rvalid, d_rvalid, c_rdata, d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_hazard();
    drive_d(1'b1, 1'b1, 5'd31, 8'h3C);
    @(negedge clk);
    n_vec++;
    if ({d_gnt, c_gnt, mem_w, mem_addr, mem_wdata} !== {3'b101, 5'd31, 8'h3C}) begin
      n_err++;
      $display("FAIL hazard_wr got gnt=%b%b w=%b addr=%h wd=%h need 10 1 1f 3c",
               d_gnt, c_gnt, mem_w, mem_addr, mem_wdata);
    end
    next_cycle();
    drive_d(1'b0, 1'b0, '0, '0);
    drive_c(1'b1, 1'b0, 5'd31, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({c_gnt, mem_w, mem_addr} !== {2'b10, 5'd31}) begin
      n_err++;
      $display("FAIL hazard_rd_gnt got gnt=%b w=%b addr=%h need 1 0 1f", c_gnt, mem_w, mem_addr);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, 8'h3C}) begin
      n_err++;
      $display("FAIL hazard_rd_data got rv=%b%b c_rdata=%h need 10 3c", c_rvalid, d_rvalid, c_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    preload(5'd4, 8'h44);
    drive_c(1'b1, 1'b0, 5'd4, 8'h00);
    @(negedge clk);
    n_vec++;
    if (c_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre_gnt got %b need 1", c_gnt);
    end
    next_cycle();
    rst = 1'b1;
    drive_d(1'b1, 1'b0, 5'd6, 8'h00);
    @(negedge clk);
    n_vec++;
    if ({c_gnt, d_gnt, mem_w, c_rvalid, c_rdata} !== {4'b0001, 8'h44}) begin
      n_err++;
      $display("FAIL midrst_during got gnt=%b%b w=%b rv=%b c_rdata=%h need 00 0 1 44",
               c_gnt, d_gnt, mem_w, c_rvalid, c_rdata);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, d_rvalid, c_rdata} !== {2'b00, 8'h00}) begin
      n_err++;
      $display("FAIL midrst_after got rv=%b%b c_rdata=%h need 00 00", c_rvalid, d_rvalid, c_rdata);
    end
`ifdef DMEM_ARB_CLEAR_EN
    begin
      int k = 0;
      while (busy && k < 100) begin
        next_cycle();
        k++;
      end
      @(negedge clk);
    end
`endif
    n_vec++;
    if ({c_gnt, d_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL midrst_tie got gnt=%b%b need 10", c_gnt, d_gnt);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

`ifdef DMEM_ARB_CLEAR_EN
  task automatic test_clear();
    do_reset();
    preload(5'd7, 8'hFF);
    rst = 1'b1;
    drive_c(1'b1, 1'b0, 5'd7, 8'h00);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, c_gnt, mem_w, mem_addr, mem_wdata} !== {3'b101, 5'(k), 8'h00}) begin
        n_err++;
        $display("FAIL clear_step%0d got busy=%b gnt=%b w=%b addr=%h wd=%h", k,
                 busy, c_gnt, mem_w, mem_addr, mem_wdata);
      end
      next_cycle();
    end
    @(negedge clk);
    n_vec++;
    if ({busy, c_gnt, mem_addr} !== {2'b01, 5'd7}) begin
      n_err++;
      $display("FAIL clear_done got busy=%b gnt=%b addr=%h need 0 1 07", busy, c_gnt, mem_addr);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, c_rdata} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL clear_read got rv=%b c_rdata=%h need 1 00", c_rvalid, c_rdata);
    end
    next_cycle();
  endtask
`endif

  task automatic test_random();
    bit            c_pend = 0, d_pend = 0, c_due = 0, d_due = 0;
    logic          cwe = 1'b0, dwe = 1'b0;
    logic [AW-1:0] ca = '0, da = '0;
    logic [DW-1:0] cd = '0, dd = '0;
    logic [DW-1:0] v, exp_rd;
    int            win;
    logic          exp_w;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_wd;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = DW'($urandom);
      ref_mem[i] = v;
      preload(AW'(i), v);
    end
    ref_last_d = 1'b1;
    exp_c_q.delete();
    exp_d_q.delete();
    for (int n = 0; n < 400; n++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1; cwe = 1'($urandom_range(0, 1));
        ca = AW'($urandom_range(0, 7)); cd = DW'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; dwe = 1'($urandom_range(0, 1));
        da = AW'($urandom_range(0, 7)); dd = DW'($urandom);
      end
      drive_c(c_pend, cwe, ca, cd);
      drive_d(d_pend, dwe, da, dd);
      @(negedge clk);
      // Rule: lone requester wins; on a tie the port that did not win last goes.
      if (c_pend && d_pend) win = ref_last_d ? 1 : 2;
      else if (c_pend)      win = 1;
      else if (d_pend)      win = 2;
      else                  win = 0;
      exp_w = 1'b0; exp_a = '0; exp_wd = '0;
      if (win == 1) begin exp_w = cwe; exp_a = ca; exp_wd = cd; end
      if (win == 2) begin exp_w = dwe; exp_a = da; exp_wd = dd; end
      n_vec++;
      if ({c_gnt, d_gnt, mem_w, mem_addr, mem_wdata} !== {win == 1, win == 2, exp_w, exp_a, exp_wd}) begin
        n_err++;
        $display("FAIL rand_grant n=%0d got gnt=%b%b w=%b a=%h wd=%h need %b%b %b %h %h", n,
                 c_gnt, d_gnt, mem_w, mem_addr, mem_wdata, win == 1, win == 2, exp_w, exp_a, exp_wd);
      end
      n_vec++;
      if ({c_rvalid, d_rvalid} !== {c_due, d_due}) begin
        n_err++;
        $display("FAIL rand_rvalid n=%0d got %b%b need %b%b", n, c_rvalid, d_rvalid, c_due, d_due);
      end
      if (c_due) begin
        exp_rd = exp_c_q.pop_front();
        n_vec++;
        if (c_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL rand_c_rdata n=%0d got %h need %h", n, c_rdata, exp_rd);
        end
      end
      if (d_due) begin
        exp_rd = exp_d_q.pop_front();
        n_vec++;
        if (d_rdata !== exp_rd) begin
          n_err++;
          $display("FAIL rand_d_rdata n=%0d got %h need %h", n, d_rdata, exp_rd);
        end
      end
      c_due = 0; d_due = 0;
      if (win == 1) begin
        ref_last_d = 1'b0; c_pend = 0;
        if (cwe) ref_mem[ca] = cd;
        else begin exp_c_q.push_back(ref_mem[ca]); c_due = 1; end
      end else if (win == 2) begin
        ref_last_d = 1'b1; d_pend = 0;
        if (dwe) ref_mem[da] = dd;
        else begin exp_d_q.push_back(ref_mem[da]); d_due = 1; end
      end
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    n_vec++;
    if ({c_rvalid, d_rvalid} !== {c_due, d_due}) begin
      n_err++;
      $display("FAIL rand_drain got rv=%b%b need %b%b", c_rvalid, d_rvalid, c_due, d_due);
    end
    if (c_due) begin
      exp_rd = exp_c_q.pop_front();
      n_vec++;
      if (c_rdata !== exp_rd) begin
        n_err++;
        $display("FAIL rand_drain_c got %h need %h", c_rdata, exp_rd);
      end
    end
    if (d_due) begin
      exp_rd = exp_d_q.pop_front();
      n_vec++;
      if (d_rdata !== exp_rd) begin
        n_err++;
        $display("FAIL rand_drain_d got %h need %h", d_rdata, exp_rd);
      end
    end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_write_read_core();
    test_simultaneous();
    test_contention();
    test_hazard();
    test_reset_mid_read();
`ifdef DMEM_ARB_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
